vec_mul_sequencer: RTL
======================

VEC_MUL_SEQUENCER -- requirements
Module: vec_mul_sequencer

Interface
REQ-001 SHALL have parameter ADDRESSSIZE, default 10, the Unified Buffer and result SRAM address width.
REQ-002 SHALL have parameter WBANK_AW, default 2, the weight-bank address width.
REQ-003 SHALL have parameter WLOAD_CYC, default 2, the number of cycles weight_reload is held.
REQ-004 SHALL have parameter PIPE_LAT, default 2, the cycles from ub_rd_en to the result being valid at the multiplier output (range 1..15).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: job request, sampled only in IDLE.
REQ-008 SHALL have port abort, input, 1 bit: cancels the current job.
REQ-009 SHALL have port num_vec, input, ADDRESSSIZE bits: vector count, latched at start.
REQ-010 SHALL have ports src_base and dst_base, input, ADDRESSSIZE bits each: UB read base and result write base, latched at start.
REQ-011 SHALL have port wbank_sel, input, WBANK_AW bits: weight bank to load, latched at start.
REQ-012 SHALL have outputs ub_addr (ADDRESSSIZE) and ub_rd_en (1): Unified Buffer read port.
REQ-013 SHALL have outputs wt_addr (WBANK_AW) and weight_reload (1): weight SRAM address and PE weight latch.
REQ-014 SHALL have outputs res_addr (ADDRESSSIZE) and res_wr_en (1): result SRAM write port.
REQ-015 SHALL have outputs busy (1), done (1, single-cycle pulse) and vec_count (ADDRESSSIZE, results written so far).

Function
REQ-016 SHALL implement FSM states IDLE, LOAD_W, STREAM, DRAIN, DONE.
REQ-017 In IDLE with start=1 and num_vec!=0: SHALL latch the job inputs and enter LOAD_W on the next cycle.
REQ-018 In IDLE with start=1 and num_vec=0: SHALL go directly to DONE, with no reads or writes.
REQ-019 LOAD_W: SHALL drive wt_addr=latched bank and weight_reload=1 for exactly WLOAD_CYC cycles, then enter STREAM.
REQ-020 STREAM: SHALL assert ub_rd_en for one cycle per vector, back-to-back, with ub_addr=src_base+i for i=0..num_vec-1; after the last issue it SHALL enter DRAIN.
REQ-021 SHALL delay ub_rd_en by PIPE_LAT cycles through a shift register to form res_wr_en; res_addr SHALL equal dst_base+k for the k-th write.
REQ-022 DRAIN: SHALL exit to DONE in the cycle after the final res_wr_en.
REQ-023 DONE: SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 vec_count SHALL increment on each res_wr_en, clear at job start, and hold its value in IDLE.
REQ-026 Address arithmetic SHALL be modulo 2^ADDRESSSIZE: src_base+i and dst_base+k wrap silently.
REQ-027 start while busy SHALL be ignored; job inputs SHALL NOT re-latch mid-job.
REQ-028 abort=1 in any non-IDLE state SHALL, on the next edge, return the FSM to IDLE, clear the delay line (no further res_wr_en), and suppress done; abort in IDLE SHALL be ignored.
REQ-029 If start and abort are both 1 in IDLE, start SHALL win.
REQ-030 ub_rd_en and weight_reload SHALL never be asserted in the same cycle.

Reset
REQ-031 rst=1 SHALL asynchronously force IDLE and set busy, done, ub_rd_en, weight_reload, res_wr_en and the delay line to 0, and ub_addr, wt_addr, res_addr and vec_count to 0.
REQ-032 Reset asserted mid-job SHALL discard the job; after release the block SHALL wait for a new start.

Structure
REQ-033 The FSM state encoding and the default PIPE_LAT/WLOAD_CYC constants SHALL reside in the shared package vec_mul_pkg.
REQ-034 The PIPE_LAT valid delay line SHALL be the sub-module valid_delay_line (parameters WIDTH=1, DEPTH=PIPE_LAT), with a synchronous flush input driven by abort.

Verification
REQ-035 Nominal: num_vec=4, src_base=8, dst_base=0x20, bank 2 -> weight_reload for 2 cycles, reads at 8..11, writes at 0x20..0x23 starting 2 cycles after the first read, done pulse, vec_count=4.
REQ-036 Zero length: num_vec=0 -> done one cycle after the IDLE sample, with no ub_rd_en, res_wr_en or weight_reload.
REQ-037 Wrap: src_base=0x3FE, dst_base=0x3FF, num_vec=3 -> reads at 0x3FE, 0x3FF, 0x000; writes at 0x3FF, 0x000, 0x001.
REQ-038 Abort in STREAM after 2 reads -> at most 0 further writes once abort is sampled, no done, busy=0 the next cycle.
REQ-039 Reset mid-DRAIN -> all outputs 0 immediately (asynchronously); a subsequent start with num_vec=1 completes normally.
REQ-040 start re-pulsed during STREAM -> ignored; exactly num_vec writes and a single done.

Source files
------------

// File: rtl/vec_mul_pkg.sv
// Shared definitions for the vector-multiply sequencer: FSM encoding and
// default pipeline timing constants.
package vec_mul_pkg;

  // Cycles from ub_rd_en to a valid multiplier result.
  localparam int unsigned DefPipeLat  = 2;
  // Cycles the PE weight latch is held during a weight load.
  localparam int unsigned DefWloadCyc = 2;

  typedef enum logic [2:0] {
    StIdle,
    StLoadW,
    StStream,
    StDrain,
    StDone
  } seq_state_e;

  // Every state other than idle counts as an active job.
  function automatic logic state_is_busy(seq_state_e s);
    return s != StIdle;
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth shift register that delays a qualifier by DEPTH cycles.
// A synchronous flush empties every stage so that nothing in flight emerges.
module valid_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift one stage per cycle; flush discards all in-flight entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vec_mul_sequencer.sv
// Sequencer for one vector-multiply job: loads a weight bank, streams
// num_vec vectors out of the Unified Buffer and writes the delayed results
// to consecutive result SRAM addresses.
module vec_mul_sequencer
  import vec_mul_pkg::*;
#(
  parameter int unsigned ADDRESSSIZE = 10,
  parameter int unsigned WBANK_AW    = 2,
  parameter int unsigned WLOAD_CYC   = DefWloadCyc,
  parameter int unsigned PIPE_LAT    = DefPipeLat
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDRESSSIZE-1:0] num_vec,
  input  logic [ADDRESSSIZE-1:0] src_base,
  input  logic [ADDRESSSIZE-1:0] dst_base,
  input  logic [WBANK_AW-1:0]    wbank_sel,
  output logic [ADDRESSSIZE-1:0] ub_addr,
  output logic                   ub_rd_en,
  output logic [WBANK_AW-1:0]    wt_addr,
  output logic                   weight_reload,
  output logic [ADDRESSSIZE-1:0] res_addr,
  output logic                   res_wr_en,
  output logic                   busy,
  output logic                   done,
  output logic [ADDRESSSIZE-1:0] vec_count
);

  localparam int unsigned WlW = (WLOAD_CYC > 1) ? $clog2(WLOAD_CYC) : 1;
  localparam logic [WlW-1:0] WlLast = WlW'(WLOAD_CYC - 1);
  localparam logic [ADDRESSSIZE-1:0] AddrOne = ADDRESSSIZE'(1);

  seq_state_e state_q, state_d;

  logic [ADDRESSSIZE-1:0] num_vec_q;
  logic [ADDRESSSIZE-1:0] src_base_q;
  logic [ADDRESSSIZE-1:0] dst_base_q;
  logic [WBANK_AW-1:0]    wbank_q;
  logic [ADDRESSSIZE-1:0] rd_idx_q;
  logic [ADDRESSSIZE-1:0] vec_count_q;
  logic [WlW-1:0]         wl_cnt_q;

  logic job_latch;
  logic last_issue;
  logic last_write;
  logic rd_en;
  logic wr_en;

  // Final read issue and final result write of the latched job.
  assign last_issue = (rd_idx_q == (num_vec_q - AddrOne));
  assign last_write = wr_en && (vec_count_q == (num_vec_q - AddrOne));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state strobes; abort overrides everything except idle.
  always_comb begin
    state_d       = state_q;
    job_latch     = 1'b0;
    rd_en         = 1'b0;
    weight_reload = 1'b0;
    done          = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          job_latch = 1'b1;
          state_d   = (num_vec == '0) ? StDone : StLoadW;
        end
      end
      StLoadW: begin
        weight_reload = 1'b1;
        if (wl_cnt_q == WlLast) begin
          state_d = StStream;
        end
      end
      StStream: begin
        rd_en = 1'b1;
        if (last_issue) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (last_write) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      done    = 1'b0;
    end
  end

  // Job parameters are captured only when a start is accepted in idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_vec_q  <= '0;
      src_base_q <= '0;
      dst_base_q <= '0;
      wbank_q    <= '0;
    end else if (job_latch) begin
      num_vec_q  <= num_vec;
      src_base_q <= src_base;
      dst_base_q <= dst_base;
      wbank_q    <= wbank_sel;
    end
  end

  // Weight-load cycle counter; idles at zero outside the load phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wl_cnt_q <= '0;
    end else if (state_q == StLoadW) begin
      wl_cnt_q <= wl_cnt_q + WlW'(1);
    end else begin
      wl_cnt_q <= '0;
    end
  end

  // Read index advances once per issued vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_idx_q <= '0;
    end else if (job_latch) begin
      rd_idx_q <= '0;
    end else if (rd_en) begin
      rd_idx_q <= rd_idx_q + AddrOne;
    end
  end

  // Results-written counter; also the offset for the next result address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_count_q <= '0;
    end else if (job_latch) begin
      vec_count_q <= '0;
    end else if (wr_en) begin
      vec_count_q <= vec_count_q + AddrOne;
    end
  end

  // Read strobes emerge PIPE_LAT cycles later as result write strobes.
  valid_delay_line #(
    .WIDTH (1),
    .DEPTH (PIPE_LAT)
  ) u_valid_delay (
    .clk   (clk),
    .rst   (rst),
    .flush (abort),
    .din   (rd_en),
    .dout  (wr_en)
  );

  // Addresses wrap modulo 2^ADDRESSSIZE by plain truncating addition.
  assign ub_addr   = src_base_q + rd_idx_q;
  assign res_addr  = dst_base_q + vec_count_q;
  assign wt_addr   = wbank_q;
  assign ub_rd_en  = rd_en;
  assign res_wr_en = wr_en;
  assign vec_count = vec_count_q;
  assign busy      = state_is_busy(state_q);

endmodule
